// File: rtl/mcu_ptr_bank_if.sv
// Arbiter-side bus of mcu_ptr_bank: request pulses, write qualifier, address,
// write data, completion level and read data.
// master = pointer bank, slave = memory arbiter.
interface mcu_ptr_bank_if #(
  parameter int ADDR_W = 24
);
  logic              mcu_rrq;
  logic              mcu_wrq;
  logic              mcu_write;
  logic [ADDR_W-1:0] mcu_addr_out;
  logic [7:0]        mcu_data_out;
  logic              mcu_rq_rdy;
  logic [7:0]        mcu_data_in;

  modport master (
    output mcu_rrq, mcu_wrq, mcu_write, mcu_addr_out, mcu_data_out,
    input  mcu_rq_rdy, mcu_data_in
  );

  modport slave (
    input  mcu_rrq, mcu_wrq, mcu_write, mcu_addr_out, mcu_data_out,
    output mcu_rq_rdy, mcu_data_in
  );
endinterface

// File: rtl/mcu_ptr_bank.sv
// mcu_ptr_bank: NUM_CH auto-incrementing address pointers loaded from SPI
// parameter bytes, plus a single-outstanding MCU read/write request engine
// with rq/rdy handshake, busy/overrun status and an optional request timeout.
// Optional feature macro: MCU_PTR_TIMEOUT_EN (request timeout after TIMEOUT_CYC
// cycles in WAIT). Without it WAIT waits forever and the timeout bit reads 0.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no request outstanding, accepts a start
// REQ     | one-cycle rrq or wrq pulse toward the arbiter
// WAIT    | waiting for a rising edge of mcu_rq_rdy (or timeout)
// DONE    | latch read data, apply auto-increment, return to IDLE
module mcu_ptr_bank #(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 1024,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_ready,
  input  logic                     param_ready,
  input  logic [7:0]               cmd_data,
  input  logic [7:0]               param_data,
  input  logic [31:0]              spi_byte_cnt,
  input  logic                     dma_nextaddr,
  input  logic [CH_W-1:0]          dma_tgt,
  output logic [NUM_CH*ADDR_W-1:0] ch_addr_out,
  output logic [7:0]               spi_data_out,
  output logic                     rq_busy,
  mcu_ptr_bank_if.master           arb
);

  localparam int AB = ADDR_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q [NUM_CH];
  logic [ADDR_W-1:0] ptr_d [NUM_CH];
  logic [CH_W-1:0]   act_q, act_d;
  logic              auto_q, auto_d;
  logic              wr_q, wr_d;
  logic [7:0]        dout_q, dout_d;
  logic [7:0]        spi_q, spi_d;
  logic              ovr_q, ovr_d;
  logic [1:0]        rdy_hist_q, rdy_hist_d;

  logic [CH_W-1:0]   cmd_ch;
  logic              cmd_ch_ok, dma_ok;
  logic              is_load, start_rd, start_wr, start_any, status_rd;
  logic              rdy_rise, done_inc, ovr_set, tmo_flag;
  logic [ADDR_W-1:0] load_val;

  assign cmd_ch = cmd_data[CH_W-1:0];

  // Channel numbers beyond NUM_CH only exist when NUM_CH is not a power of two.
  if ((1 << CH_W) == NUM_CH) begin : g_ch_full
    assign cmd_ch_ok = 1'b1;
    assign dma_ok    = 1'b1;
  end else begin : g_ch_part
    assign cmd_ch_ok = (cmd_ch  < CH_W'(NUM_CH));
    assign dma_ok    = (dma_tgt < CH_W'(NUM_CH));
  end

  assign is_load   = param_ready && (cmd_data[7:4] == 4'h0) && cmd_ch_ok &&
                     (spi_byte_cnt >= 32'd2) && (spi_byte_cnt <= 32'(1 + AB));
  assign start_rd  = cmd_ch_ok && (cmd_data[7:4] == 4'h8) && (cmd_ready || param_ready);
  assign start_wr  = cmd_ch_ok && (cmd_data[7:4] == 4'h9) && param_ready;
  assign start_any = start_rd || start_wr;
  assign status_rd = cmd_ready && (cmd_data == 8'hF1);
  assign rdy_rise  = (rdy_hist_q == 2'b01);
  assign rdy_hist_d = {rdy_hist_q[0], arb.mcu_rq_rdy};

  assign rq_busy          = (state_q != ST_IDLE);
  assign arb.mcu_rrq      = (state_q == ST_REQ) && !wr_q;
  assign arb.mcu_wrq      = (state_q == ST_REQ) &&  wr_q;
  assign arb.mcu_write    = !(wr_q && (state_q != ST_IDLE));
  assign arb.mcu_addr_out = ptr_q[act_q];
  assign arb.mcu_data_out = dout_q;
  assign spi_data_out     = spi_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
    assign ch_addr_out[g*ADDR_W +: ADDR_W] = ptr_q[g];
  end

`ifdef MCU_PTR_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_q, tmo_d;
  logic             tmo_set;

  // Down-counter reloaded in REQ; reaching zero in WAIT ends the request.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q == ST_REQ)
      tmo_cnt_d = TMO_W'(TIMEOUT_CYC - 1);
    else if ((state_q == ST_WAIT) && (tmo_cnt_q != '0))
      tmo_cnt_d = tmo_cnt_q - 1'b1;
    tmo_d = tmo_set | (tmo_q & ~status_rd);
  end

  // Timeout counter and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      tmo_q     <= tmo_d;
    end
  end

  assign tmo_flag = tmo_q;
`else
  // Timeout never fires in this build; the compare is constant false.
  assign tmo_flag = (TIMEOUT_CYC < 0);
`endif

  // Assembled value of the addressed pointer after the current load byte.
  always_comb begin
    load_val = ptr_q[cmd_ch];
    if (spi_byte_cnt == 32'd2)
      load_val = '0;
    for (int j = 0; j < AB; j++) begin
      if (spi_byte_cnt == 32'(j + 2))
        load_val[ADDR_W-1-8*j -: 8] = param_data;
    end
  end

  // Request FSM next state, latched request context, data and status bytes.
  always_comb begin
    state_d  = state_q;
    act_d    = act_q;
    auto_d   = auto_q;
    wr_d     = wr_q;
    dout_d   = dout_q;
    spi_d    = spi_q;
    done_inc = 1'b0;
    ovr_set  = 1'b0;
`ifdef MCU_PTR_TIMEOUT_EN
    tmo_set  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_any) begin
          state_d = ST_REQ;
          act_d   = cmd_ch;
          auto_d  = cmd_data[3];
          wr_d    = start_wr;
          if (start_wr)
            dout_d = param_data;
        end
      end
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (rdy_rise)
          state_d = ST_DONE;
`ifdef MCU_PTR_TIMEOUT_EN
        else if (tmo_cnt_q == '0) begin
          state_d = ST_IDLE;
          tmo_set = 1'b1;
        end
`endif
      end
      ST_DONE: begin
        state_d  = ST_IDLE;
        done_inc = auto_q;
        if (!wr_q)
          spi_d = arb.mcu_data_in;
      end
      default: state_d = ST_IDLE;
    endcase
    if (start_any && (state_q != ST_IDLE))
      ovr_set = 1'b1;
    // A status read takes the SPI byte even in the DONE cycle of a read.
    if (status_rd)
      spi_d = {rq_busy, ovr_q, tmo_flag, 5'b0};
    ovr_d = ovr_set | (ovr_q & ~status_rd);
  end

  // Per-channel pointer update: a load byte wins, otherwise DMA and DONE increments add up.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      logic [1:0] inc;
      inc = {1'b0, dma_nextaddr && dma_ok && (dma_tgt == CH_W'(c))} +
            {1'b0, done_inc && (act_q == CH_W'(c))};
      if (is_load && (cmd_ch == CH_W'(c)))
        ptr_d[c] = load_val;
      else
        ptr_d[c] = ptr_q[c] + ADDR_W'(inc);
    end
  end

  // State, pointers, request context and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_q      <= '0;
      auto_q     <= 1'b0;
      wr_q       <= 1'b0;
      dout_q     <= '0;
      spi_q      <= '0;
      ovr_q      <= 1'b0;
      rdy_hist_q <= '0;
      for (int c = 0; c < NUM_CH; c++)
        ptr_q[c] <= '0;
    end else begin
      state_q    <= state_d;
      act_q      <= act_d;
      auto_q     <= auto_d;
      wr_q       <= wr_d;
      dout_q     <= dout_d;
      spi_q      <= spi_d;
      ovr_q      <= ovr_d;
      rdy_hist_q <= rdy_hist_d;
      for (int c = 0; c < NUM_CH; c++)
        ptr_q[c] <= ptr_d[c];
    end
  end

endmodule

// File: tb/tb_mcu_ptr_bank.sv
// Bench for mcu_ptr_bank: directed SPI/DMA stimulus, a responding arbiter,
// a transaction-level model of the pointers and SPI bytes, and a compare
// process that checks the model whenever the request engine is idle.
module tb_mcu_ptr_bank;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 24;
  localparam int AB     = ADDR_W / 8;
  localparam int CH_W   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cmd_ready = 1'b0, param_ready = 1'b0;
  logic [7:0]               cmd_data = '0, param_data = '0;
  logic [31:0]              spi_byte_cnt = '0;
  logic                     dma_nextaddr = 1'b0;
  logic [CH_W-1:0]          dma_tgt = '0;
  logic [NUM_CH*ADDR_W-1:0] ch_addr_out;
  logic [7:0]               spi_data_out;
  logic                     rq_busy;

  mcu_ptr_bank_if #(.ADDR_W(ADDR_W)) bus();

  mcu_ptr_bank #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_ready(cmd_ready), .param_ready(param_ready),
    .cmd_data(cmd_data), .param_data(param_data), .spi_byte_cnt(spi_byte_cnt),
    .dma_nextaddr(dma_nextaddr), .dma_tgt(dma_tgt), .ch_addr_out(ch_addr_out),
    .spi_data_out(spi_data_out), .rq_busy(rq_busy), .arb(bus)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int rrq_cnt = 0, wrq_cnt = 0;
  bit chk_en = 1'b0;
  bit arb_en = 1'b1;
  int arb_dly = 3;
  logic [7:0] arb_data = '0;

  // Model state
  logic [ADDR_W-1:0] ptr_m [NUM_CH];
  logic [7:0]        spi_m = '0, dout_m = '0;
  int                act_m = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*ADDR_W-1:0] flat_m();
    logic [NUM_CH*ADDR_W-1:0] f;
    for (int c = 0; c < NUM_CH; c++) f[c*ADDR_W +: ADDR_W] = ptr_m[c];
    return f;
  endfunction

  // Byte k of a load lands at the k-th byte from the top; the first byte clears the rest.
  task automatic m_load(input int ch, input int k, input logic [7:0] d);
    int sh;
    if (k >= 2 && k <= 1 + AB) begin
      sh = 8 * (AB + 1 - k);
      if (k == 2) ptr_m[ch] = '0;
      ptr_m[ch] = (ptr_m[ch] & ~(ADDR_W'(8'hFF) << sh)) | (ADDR_W'(d) << sh);
    end
  endtask

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) ptr_m[c] = '0;
    spi_m = '0; dout_m = '0; act_m = 0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic cmd_strobe(input logic [7:0] c);
    cmd_data = c; spi_byte_cnt = 32'd1; cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic param_strobe(input logic [7:0] d, input int k);
    param_data = d; spi_byte_cnt = 32'(k); param_ready = 1'b1;
    @(posedge clk); #1;
    param_ready = 1'b0;
  endtask

  task automatic dma_strobe(input int t);
    dma_tgt = CH_W'(t); dma_nextaddr = 1'b1;
    @(posedge clk); #1;
    dma_nextaddr = 1'b0;
  endtask

  task automatic wait_idle(input int max, input string name, output int n);
    n = 0;
    while (rq_busy && n < max) begin tick(1); n++; end
    check(name, rq_busy, 0);
  endtask

  // Request pulse counters
  always @(negedge clk) begin
    if (bus.mcu_rrq) rrq_cnt++;
    if (bus.mcu_wrq) wrq_cnt++;
  end

  // Arbiter: answers each request arb_dly cycles later, holds rdy for 3 cycles.
  initial begin
    bus.mcu_rq_rdy = 1'b0;
    bus.mcu_data_in = '0;
    forever begin
      @(negedge clk);
      if (arb_en && (bus.mcu_rrq || bus.mcu_wrq)) begin
        repeat (arb_dly) @(posedge clk);
        #1;
        bus.mcu_rq_rdy = 1'b1;
        bus.mcu_data_in = arb_data;
        repeat (3) @(posedge clk);
        #1;
        bus.mcu_rq_rdy = 1'b0;
      end
    end
  end

  // Compare process: whenever idle, every output must match the model.
  always @(negedge clk) begin
    if (chk_en && rst_n && !rq_busy) begin
      check("ch_addr_out", ch_addr_out, flat_m());
      check("mcu_addr_out", bus.mcu_addr_out, ptr_m[act_m]);
      check("spi_data_out", spi_data_out, spi_m);
      check("mcu_data_out", bus.mcu_data_out, dout_m);
      check("idle_rrq_wrq_write", {bus.mcu_rrq, bus.mcu_wrq, bus.mcu_write}, 3'b001);
    end
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    int n, r0, w0;
    m_reset();
    #2;
    check("rst_busy", rq_busy, 0);
    check("rst_ctrl", {bus.mcu_rrq, bus.mcu_wrq, bus.mcu_write}, 3'b001);
    check("rst_ptrs", ch_addr_out, 0);
    check("rst_spi", spi_data_out, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: load ch1 = 0x123456; a fourth byte is ignored
    cmd_strobe(8'h01);
    param_strobe(8'h12, 2); m_load(1, 2, 8'h12);
    param_strobe(8'h34, 3); m_load(1, 3, 8'h34);
    param_strobe(8'h56, 4); m_load(1, 4, 8'h56);
    param_strobe(8'h99, 5); m_load(1, 5, 8'h99);
    tick(1);
    check("load_ch1", ch_addr_out[47:24], 24'h123456);
    check("load_ch0_untouched", ch_addr_out[23:0], 24'h000000);

    // 2: ptr0 = 0xFFFFFF, auto-inc read wraps to 0
    cmd_strobe(8'h00);
    param_strobe(8'hFF, 2); m_load(0, 2, 8'hFF);
    param_strobe(8'hFF, 3); m_load(0, 3, 8'hFF);
    param_strobe(8'hFF, 4); m_load(0, 4, 8'hFF);
    tick(1);
    check("load_ch0_ff", ch_addr_out[23:0], 24'hFFFFFF);
    arb_en = 1'b1; arb_dly = 3; arb_data = 8'hA5; r0 = rrq_cnt;
    cmd_strobe(8'h88); act_m = 0;
    wait_idle(30, "read_inc_idle", n);
    spi_m = 8'hA5; ptr_m[0] = ptr_m[0] + 1'b1;
    check("read_inc_cycles", n, 6);
    check("read_inc_spi", spi_data_out, 8'hA5);
    check("read_inc_wrap", ch_addr_out[23:0], 24'h000000);
    check("read_one_rrq", rrq_cnt - r0, 1);
    tick(3);

    // 3: write ch2 without auto, DMA to ch0 while busy
    arb_dly = 2; w0 = wrq_cnt;
    cmd_strobe(8'h92);
    param_strobe(8'h5A, 2); act_m = 2; dout_m = 8'h5A;
    check("write_data", bus.mcu_data_out, 8'h5A);
    check("write_qual_req", bus.mcu_write, 0);
    tick(2);
    dma_strobe(0); ptr_m[0] = ptr_m[0] + 1'b1;
    check("write_qual_wait", bus.mcu_write, 0);
    wait_idle(30, "write_idle", n);
    check("write_one_wrq", wrq_cnt - w0, 1);
    check("write_ch2_untouched", ch_addr_out[71:48], 24'h000000);
    check("dma_other_ch0", ch_addr_out[23:0], 24'h000001);
    tick(3);

    // 4: overrun during WAIT, status while busy, status after completion
    arb_dly = 8; arb_data = 8'h3C; r0 = rrq_cnt;
    cmd_strobe(8'h80); act_m = 0;
    tick(2);
    param_strobe(8'h77, 2);
    cmd_strobe(8'hF1);
    check("status_busy_ovr", spi_data_out, 8'hC0);
    wait_idle(40, "overrun_idle", n);
    spi_m = 8'h3C;
    check("overrun_no_extra_rrq", rrq_cnt - r0, 1);
    tick(3);
    cmd_strobe(8'hF1); spi_m = 8'h00;
    check("status_cleared", spi_data_out, 8'h00);

    // 5a: DONE increment and DMA on ch1 in the same cycle -> +2
    arb_dly = 0; arb_data = 8'h11;
    cmd_strobe(8'h89); act_m = 1;
    tick(2);
    check("busy_in_done", rq_busy, 1);
    dma_strobe(1);
    ptr_m[1] = ptr_m[1] + 2'd2; spi_m = 8'h11;
    check("min_latency_idle", rq_busy, 0);
    check("collide_inc2", ch_addr_out[47:24], 24'h123458);
    tick(3);

    // 5b: load byte and DMA on ch3 in one cycle -> loaded value
    cmd_strobe(8'h03);
    dma_tgt = 2'd3; dma_nextaddr = 1'b1;
    param_strobe(8'hAB, 2); m_load(3, 2, 8'hAB);
    dma_nextaddr = 1'b0;
    check("load_beats_dma", ch_addr_out[95:72], 24'hAB0000);
    param_strobe(8'hCD, 3); m_load(3, 3, 8'hCD);
    param_strobe(8'hEF, 4); m_load(3, 4, 8'hEF);
    check("load_ch3", ch_addr_out[95:72], 24'hABCDEF);
    dma_strobe(3); ptr_m[3] = ptr_m[3] + 1'b1;
    tick(2);

`ifdef MCU_PTR_TIMEOUT_EN
    // 6: no rdy -> IDLE after 16 WAIT cycles, timeout status, pointer unchanged
    arb_en = 1'b0;
    cmd_strobe(8'h8E); act_m = 2;
    tick(16);
    check("tmo_still_busy", rq_busy, 1);
    tick(1);
    check("tmo_idle", rq_busy, 0);
    check("tmo_ptr2", ch_addr_out[71:48], 24'h000000);
    cmd_strobe(8'hF1); spi_m = 8'h20;
    check("tmo_status", spi_data_out, 8'h20);
    cmd_strobe(8'hF1); spi_m = 8'h00;
    check("tmo_status_clear", spi_data_out, 8'h00);
    tick(2);
`endif

    // Reset asserted mid-WAIT
    arb_en = 1'b0;
    cmd_strobe(8'h80); act_m = 0;
    tick(5);
    check("wait_busy", rq_busy, 1);
`ifndef MCU_PTR_TIMEOUT_EN
    tick(30);
    check("no_timeout_busy", rq_busy, 1);
`endif
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", rq_busy, 0);
    check("async_rst_ctrl", {bus.mcu_rrq, bus.mcu_wrq, bus.mcu_write}, 3'b001);
    check("async_rst_ptrs", ch_addr_out, 0);
    check("async_rst_spi", spi_data_out, 0);
    check("async_rst_dout", bus.mcu_data_out, 0);
    m_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cmd_strobe(8'hF1); spi_m = 8'h00;
    check("post_rst_status", spi_data_out, 8'h00);
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
